// File: rtl/lz77_decoder_pkg.sv
// Constants, token layout and FSM state type shared by the LZ77 encoder and decoder.
package lz77_decoder_pkg;

  localparam int SEARCH_DEPTH = 7;
  localparam int MAX_MATCH    = 2;
  localparam int OFF_W        = 4;
  localparam int LEN_W        = 3;
  localparam int CHAR_W       = 8;

  localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    LIT  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  len;
    logic [CHAR_W-1:0] ch;
  } token_t;

endpackage

// File: rtl/lz77_decoder_if.sv
// Token input handshake and decoded character output of the LZ77 decoder.
interface lz77_decoder_if;
  import lz77_decoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OFF_W-1:0]  offset;
  logic [LEN_W-1:0]  match_len;
  logic [CHAR_W-1:0] char_nxt;
  logic              out_valid;
  logic [CHAR_W-1:0] out_char;
  logic              finish;

  modport master (
    output in_valid, offset, match_len, char_nxt,
    input  in_ready, out_valid, out_char, finish
  );

  modport slave (
    input  in_valid, offset, match_len, char_nxt,
    output in_ready, out_valid, out_char, finish
  );

endinterface

// File: rtl/lz77_decoder_history.sv
// History shift register: newest char enters at index 0, oldest falls off the end.
// Reads beyond the depth return zero.
module lz77_history #(
  parameter int DEPTH = 7,
  parameter int W     = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_i,
  input  logic [W-1:0]     din_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [W-1:0]     dout_o
);

  logic [W-1:0] hist_q [DEPTH];
  logic [W-1:0] hist_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) hist_d[i] = hist_q[i];
    if (shift_i) begin
      hist_d[0] = din_i;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) hist_q[i] <= '0;
      else       hist_q[i] <= hist_d[i];
    end
  end

  always_comb begin
    dout_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_i == IDX_W'(i)) dout_o = hist_q[i];
    end
  end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: copies match_len chars from history, then emits the literal.
// state | meaning
// IDLE  | waiting for a token, nothing emitted
// COPY  | emitting one history char per cycle
// LIT   | emitting the literal; may accept the next token on the same edge
// DONE  | end char emitted; finish held until reset
module lz77_decoder
  import lz77_decoder_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  lz77_decoder_if.slave bus
);

  state_e            state_q, state_d;
  token_t            tok_q, tok_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [CHAR_W-1:0] out_char_q, out_char_d;
  logic              finish_q, finish_d;

  logic              ready;
  logic              in_ready_w;
  logic              take;
  logic              shift_en;
  logic [CHAR_W-1:0] shift_char;
  logic [CHAR_W-1:0] hist_char;

  lz77_history #(
    .DEPTH (SEARCH_DEPTH),
    .W     (CHAR_W),
    .IDX_W (OFF_W)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .shift_i (shift_en),
    .din_i   (shift_char),
    .idx_i   (tok_q.offset),
    .dout_o  (hist_char)
  );

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE:    ready = 1'b1;
      LIT:     ready = (tok_q.ch != END_CHAR);
      default: ready = 1'b0;
    endcase
  end

  assign in_ready_w = ready & ~reset;
  assign take       = bus.in_valid & in_ready_w;

  always_comb begin
    state_d     = state_q;
    tok_d       = tok_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_char_d  = out_char_q;
    finish_d    = finish_q;
    shift_en    = 1'b0;
    shift_char  = hist_char;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          tok_d   = {bus.offset, bus.match_len, bus.char_nxt};
          cnt_d   = bus.match_len;
          state_d = (bus.match_len != '0) ? COPY : LIT;
        end
      end
      COPY: begin
        // Source index stays fixed while history shifts, so overlapping copies work.
        out_valid_d = 1'b1;
        out_char_d  = hist_char;
        shift_en    = 1'b1;
        shift_char  = hist_char;
        cnt_d       = cnt_q - LEN_W'(1);
        if (cnt_q <= LEN_W'(1)) state_d = LIT;
      end
      LIT: begin
        out_valid_d = 1'b1;
        out_char_d  = tok_q.ch;
        shift_en    = 1'b1;
        shift_char  = tok_q.ch;
        if (tok_q.ch == END_CHAR) begin
          state_d  = DONE;
          finish_d = 1'b1;
        end else if (take) begin
          tok_d   = {bus.offset, bus.match_len, bus.char_nxt};
          cnt_d   = bus.match_len;
          state_d = (bus.match_len != '0) ? COPY : LIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tok_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tok_q       <= tok_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      finish_q    <= finish_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;
  assign bus.finish    = finish_q;

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed bench for lz77_decoder: token groups with hand-decoded expected streams,
// plus sequences for reset, DONE and reset during a copy.
module tb_lz77_decoder;
  import lz77_decoder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lz77_decoder_if bus ();

  lz77_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] obs_q [$];
  int first_cyc = 0;
  int last_cyc  = 0;
  int rdy_low   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (obs_q.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      obs_q.push_back(bus.out_char);
    end
    if (!reset && !bus.in_ready) rdy_low++;
  end

  typedef struct {
    int         grp;
    logic [3:0] off;
    logic [2:0] len;
    logic [7:0] ch;
  } vec_t;

  localparam int NGRP = 8;
  vec_t  vecs [$];
  string gexp [NGRP];
  bit    ggap [NGRP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input int g, input int off, input int len, input byte ch);
    vec_t v;
    v.grp = g;
    v.off = 4'(off);
    v.len = 3'(len);
    v.ch  = ch;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    obs_q.delete();
    rdy_low = 0;
  endtask

  // Returns right after the handshake edge; in_valid is still high with this token.
  task automatic send(input vec_t v, input bit gaps, output bit ok);
    int n;
    int g;
    @(negedge clk);
    if (gaps) begin
      g = $urandom_range(0, 3);
      if (g > 0) begin
        bus.in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    bus.in_valid  = 1'b1;
    bus.offset    = v.off;
    bus.match_len = v.len;
    bus.char_nxt  = v.ch;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    @(posedge clk);
  endtask

  task automatic drain(input int want);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (obs_q.size() < want && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit ok;
    byte e;
    vec_t v;

    bus.in_valid  = 1'b0;
    bus.offset    = '0;
    bus.match_len = '0;
    bus.char_nxt  = '0;

    // Expected streams: '_' stands for a zero byte.
    add(0, 0, 0, "a"); add(0, 0, 0, "b"); add(0, 0, 0, "$");
    gexp[0] = "ab$"; ggap[0] = 0;
    add(1, 0, 0, "a"); add(1, 0, 0, "b"); add(1, 1, 2, "c");
    gexp[1] = "ababc"; ggap[1] = 0;
    add(2, 0, 0, "x"); add(2, 0, 2, "y");
    gexp[2] = "xxxy"; ggap[2] = 0;
    add(3, 0, 0, "1"); add(3, 0, 0, "2"); add(3, 0, 0, "3"); add(3, 0, 0, "4");
    add(3, 0, 0, "5"); add(3, 0, 0, "6"); add(3, 0, 0, "7"); add(3, 6, 2, "$");
    gexp[3] = "123456712$"; ggap[3] = 0;
    add(4, 0, 0, "a"); add(4, 9, 2, "q");
    gexp[4] = "a__q"; ggap[4] = 0;
    add(5, 0, 0, "a"); add(5, 0, 0, "b"); add(5, 1, 2, "c"); add(5, 0, 2, "y");
    gexp[5] = "ababcccy"; ggap[5] = 0;
    add(6, 0, 0, "a"); add(6, 0, 0, "b"); add(6, 1, 2, "c"); add(6, 0, 2, "y");
    gexp[6] = "ababcccy"; ggap[6] = 1;
    add(7, 0, 0, "a"); add(7, 0, 3, "b");
    gexp[7] = "aaaab"; ggap[7] = 0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_char",  32'(bus.out_char),  32'd0);
    check("rst finish",    32'(bus.finish),    32'd0);
    check("rst in_ready",  32'(bus.in_ready),  32'd0);

    for (int g = 0; g < NGRP; g++) begin
      do_reset();
      check($sformatf("g%0d idle in_ready", g), 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < vecs.size(); i++) begin
        if (vecs[i].grp == g) begin
          v = vecs[i];
          send(v, ggap[g], ok);
          if (!ok) check($sformatf("g%0d handshake timeout", g), 32'd0, 32'd1);
        end
      end
      drain(gexp[g].len());
      check($sformatf("g%0d char count", g), 32'(obs_q.size()), 32'(gexp[g].len()));
      for (int i = 0; i < gexp[g].len(); i++) begin
        e = gexp[g][i];
        if (e == "_") e = 8'h00;
        if (i < obs_q.size())
          check($sformatf("g%0d char %0d", g, i), 32'(obs_q[i]), 32'(e));
        else
          check($sformatf("g%0d char %0d missing", g, i), 32'd0, 32'd1);
      end
      if (!ggap[g] && obs_q.size() > 0)
        check($sformatf("g%0d contiguous out_valid", g),
              32'(last_cyc - first_cyc + 1), 32'(gexp[g].len()));

      if (g == 1) check("g1 in_ready low cycles", 32'(rdy_low), 32'd2);
      if (g == 1 || g == 5) check($sformatf("g%0d finish", g), 32'(bus.finish), 32'd0);

      if (g == 0 || g == 3) begin
        check($sformatf("g%0d done finish", g),    32'(bus.finish),    32'd1);
        check($sformatf("g%0d done out_valid", g), 32'(bus.out_valid), 32'd0);
        check($sformatf("g%0d done in_ready", g),  32'(bus.in_ready),  32'd0);
        bus.in_valid  = 1'b1;
        bus.offset    = 4'd0;
        bus.match_len = 3'd1;
        bus.char_nxt  = "k";
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        check($sformatf("g%0d done ignores input", g), 32'(obs_q.size()), 32'(gexp[g].len()));
        check($sformatf("g%0d done finish held", g), 32'(bus.finish), 32'd1);
      end
    end

    // Reset during the first COPY cycle of (1,2,'c')
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].grp == 1) begin
        v = vecs[i];
        send(v, 1'b0, ok);
        if (!ok) check("rcopy handshake timeout", 32'd0, 32'd1);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rcopy out_valid", 32'(bus.out_valid), 32'd0);
    check("rcopy finish",    32'(bus.finish),    32'd0);
    check("rcopy in_ready during reset", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rcopy in_ready after reset", 32'(bus.in_ready), 32'd1);
    obs_q.delete();
    v.grp = 9; v.off = 4'd0; v.len = 3'd1; v.ch = "z";
    send(v, 1'b0, ok);
    if (!ok) check("rcopy z handshake timeout", 32'd0, 32'd1);
    drain(2);
    check("rcopy char count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2) begin
      check("rcopy cleared history", 32'(obs_q[0]), 32'h00);
      check("rcopy literal z",       32'(obs_q[1]), 32'(8'h7a));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lz77_decoder.md
LZ77_DECODER -- requirements
Module: lz77_decoder

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  token on offset/match_len/char_nxt is valid this cycle.
REQ-004 in_ready  output  1  decoder accepts a token at this edge if in_valid=1.
REQ-005 offset  input  4  match start in history: 0 = most recent char; legal 0..6.
REQ-006 match_len  input  3  number of chars to copy; legal 0..2; 3..7 are honoured as given.
REQ-007 char_nxt  input  8  literal char emitted after the copy.
REQ-008 out_valid  output  1  out_char holds a decoded char this cycle (registered).
REQ-009 out_char  output  8  decoded char (registered).
REQ-010 finish  output  1  high from the cycle after '$' (8'h24) is emitted until reset (registered).

Function
REQ-011 The decoder SHALL keep a 7-entry, 8-bit history shift register hist[0..6], with hist[0] the newest char; each emitted char shifts in at hist[0], and hist[6] is discarded.
REQ-012 The FSM SHALL have the states IDLE, COPY, LIT and DONE.
REQ-013 in_ready SHALL be combinational:
- 1 in IDLE;
- 1 in LIT when the latched literal is not 8'h24;
- 0 otherwise.
REQ-014 On a handshake (in_valid & in_ready at an edge), the decoder SHALL latch offset, match_len and char_nxt, load cnt=match_len, and go to COPY if match_len≠0, else to LIT.
REQ-015 In COPY, each edge SHALL:
- emit out_char<=hist[offset] with out_valid<=1;
- shift that char into history;
- decrement cnt.
It SHALL go to LIT when cnt reaches 1.
REQ-016 Overlapping copies SHALL be correct: because the source index stays at offset after each shift, offset=0 with len=2 repeats the newest char twice.
REQ-017 For offset>6, copied chars SHALL be 8'h00, and the history SHALL still shift.
REQ-018 In LIT, the edge SHALL emit out_char<=latched char_nxt with out_valid<=1 and shift it into history.
- If that char is 8'h24: go to DONE and set finish<=1.
- Else, if a handshake occurs at that edge: accept the new token per REQ-014.
- Else: go to IDLE.
REQ-019 Latency and throughput:
- Token accepted at edge k → its chars are valid in the cycles after edges k+1 .. k+match_len+1.
- Back-to-back tokens SHALL sustain one token per match_len+1 cycles with no gap in out_valid.
REQ-020 out_valid SHALL be 0 in every cycle where no char is emitted (after IDLE edges and in DONE).
REQ-021 In DONE, in_ready SHALL be 0, out_valid 0, finish 1, and inputs SHALL be ignored.
REQ-022 in_valid arriving while in_ready=0 SHALL be ignored without loss of decoder state; the source holds the token until accepted.
REQ-023 match_len/offset SHALL be latched only at the handshake; input changes during COPY SHALL have no effect.

Reset
REQ-024 Reset SHALL take priority over all other activity, including mid-COPY and in DONE.
REQ-025 At the next edge, reset SHALL set:
- state=IDLE;
- hist all 8'h00;
- cnt=0;
- latched token 0;
- out_valid=0, out_char=8'h00, finish=0.
REQ-026 While reset=1, in_ready SHALL be 0.

Structure
REQ-027 The shared LZ77 package SHALL hold the following, which are shared with the encoder:
- SEARCH_DEPTH=7;
- MAX_MATCH=2;
- END_CHAR=8'h24;
- the offset/len/char widths (4/3/8);
- the FSM state enum.
REQ-028 The history shift register SHALL be a sub-module lz77_history (shift-in, read port at index, depth param), instantiated once.

Verification
REQ-029 Literals only: tokens (0,0,'a'),(0,0,'b'),(0,0,'$') sent back-to-back → out_char a,b,$ on consecutive cycles, then finish=1 one cycle after '$'.
REQ-030 Copy: tokens (0,0,'a'),(0,0,'b'),(1,2,'c') → a,b,a,b,c; in_ready is 0 for exactly the 2 COPY cycles.
REQ-031 Overlap: tokens (0,0,'x'),(0,2,'y') → x,x,x,y.
REQ-032 Max window: seven literals '1'..'7', then (6,2,'$') → ...,'1','2','$'; finish=1, and a later in_valid is ignored.
REQ-033 Reset mid-COPY: reset asserted during the first COPY cycle of (1,2,'c') → next cycle out_valid=0, finish=0, in_ready=1 after reset drops, and history cleared (a following (0,1,'z') yields 8'h00,'z').
REQ-034 Stall: in_valid held with random gaps → output stream identical to the gap-free run, and no token is dropped or duplicated.
